// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the 4x4 hex keypad scanner and its debounce FSM.
//   - Debounce FSM state encodings (IDLE / CAND / HELD).
//   - Frame-result enum (NONE / SINGLE / MULTI).
//   - Row/column to hex-code key map and a lookup helper.
//   - Command key codes used when KEYPAD_CMD_KEYS_EN is defined.
// No ports; imported with "import keypad_pkg::*".

package keypad_pkg;

    // Debounce FSM states, kept as plain constants so older tools accept them.
    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE = 2'd0;
    localparam fsm_state_t ST_CAND = 2'd1;
    localparam fsm_state_t ST_HELD = 2'd2;

    // Outcome of one full four-column scan.
    typedef enum logic [1:0] {
        FRAME_NONE   = 2'd0,
        FRAME_SINGLE = 2'd1,
        FRAME_MULTI  = 2'd2
    } frame_result_t;

    localparam logic [3:0] KEY_BACKSPACE = 4'hE;
    localparam logic [3:0] KEY_ENTER     = 4'hF;

    // Indexed by {row, col}. Row 0 is the top of the keypad:
    //   row0: 1 2 3 A
    //   row1: 4 5 6 B
    //   row2: 7 8 9 C
    //   row3: E 0 F D
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[{row, col}];
    endfunction

endpackage

// File: rtl/keypad_debounce_fsm.sv
// keypad_debounce_fsm
// Press/release debouncer for the keypad scanner. Advances once per frame
// evaluation: a key must be seen alone for DEBOUNCE_SCANS consecutive frames
// to be accepted, and the pad must read empty for DEBOUNCE_SCANS consecutive
// frames before another key can be accepted.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   eval_strobe     one-cycle strobe on the frame evaluation edge
//   frame_result    NONE / SINGLE / MULTI for the frame being evaluated
//   frame_code      hex code of the key when frame_result is SINGLE
//   accept          combinational, high on the evaluation edge that accepts a key
//   accept_code     code of the accepted key (valid while accept is high)

module keypad_debounce_fsm
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          eval_strobe,
    input  frame_result_t frame_result,
    input  logic [3:0]    frame_code,
    output logic          accept,
    output logic [3:0]    accept_code
);

    localparam logic [3:0] DEB_TARGET = 4'(DEBOUNCE_SCANS);

    fsm_state_t state_q, state_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] rel_q, rel_d;

    // Next-state logic. accept is produced here so the top level can register
    // key_valid/value on the same edge the FSM moves into HELD.
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        rel_d       = rel_q;
        accept      = 1'b0;
        accept_code = cand_q;

        if (eval_strobe) begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_result == FRAME_SINGLE) begin
                        cand_d = frame_code;
                        cnt_d  = 4'd1;
                        if (DEB_TARGET == 4'd1) begin
                            accept      = 1'b1;
                            accept_code = frame_code;
                            state_d     = ST_HELD;
                            rel_d       = 4'd0;
                        end else begin
                            state_d = ST_CAND;
                        end
                    end
                end

                ST_CAND: begin
                    if (frame_result == FRAME_SINGLE) begin
                        if (frame_code == cand_q) begin
                            cnt_d = cnt_q + 4'd1;
                            if (cnt_q + 4'd1 == DEB_TARGET) begin
                                accept      = 1'b1;
                                accept_code = cand_q;
                                state_d     = ST_HELD;
                                rel_d       = 4'd0;
                            end
                        end else begin
                            // A different key restarts the count rather than dropping to IDLE.
                            cand_d = frame_code;
                            cnt_d  = 4'd1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end
                end

                ST_HELD: begin
                    // Anything other than an empty pad (including rollover) keeps us
                    // here and restarts the release count, so no second event fires.
                    if (frame_result == FRAME_NONE) begin
                        if (rel_q + 4'd1 == DEB_TARGET) begin
                            state_d = ST_IDLE;
                            rel_d   = 4'd0;
                            cnt_d   = 4'd0;
                        end else begin
                            rel_d = rel_q + 4'd1;
                        end
                    end else begin
                        rel_d = 4'd0;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                    rel_d   = 4'd0;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cand_q  <= 4'd0;
            cnt_q   <= 4'd0;
            rel_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 hex keypad by driving one column low at a time and sampling the
// rows, debounces presses and shifts each accepted digit into a 32-bit entry
// register (most recent digit in value[3:0]).
// Optional feature macro: KEYPAD_CMD_KEYS_EN
//   defined   : E(*) is backspace, F(#) is enter (pulses value_ready, value kept)
//   undefined : all keys shift in and value_ready pulses with every key_valid
// Ports:
//   clk          system clock
//   rst          synchronous active-low reset
//   row_in[3:0]  keypad rows, active-low, asynchronous
//   col_out[3:0] column drive, active-low one-hot
//   clear        synchronous pulse, zeroes value
//   key_valid    one-cycle pulse per accepted key
//   key_code     code of the last accepted key
//   value[31:0]  entry register
//   value_ready  one-cycle pulse (see macro above)

module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 10_000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    input  logic        clear,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [31:0] value,
    output logic        value_ready
);

    localparam int              DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [1:0]       hits_q, hits_d;
    logic [3:0]       acc_code_q, acc_code_d;
    logic             key_valid_q, key_valid_d;
    logic [3:0]       key_code_q, key_code_d;
    logic [31:0]      value_q, value_d;
    logic             value_ready_q, value_ready_d;

    logic             sample;
    logic             eval_strobe;
    logic [3:0]       col_lows;
    logic [2:0]       col_hits;
    logic [1:0]       col_row;
    logic [1:0]       frame_hits;
    logic [3:0]       frame_code;
    frame_result_t    frame_result;
    logic             accept;
    logic [3:0]       accept_code;
    logic [31:0]      value_base;

    // Two-flop synchronizer on the raw row pins.
    always_comb begin
        sync1_d = row_in;
        sync2_d = sync1_q;
    end

    // Dwell divider and column rotation. Rows are sampled on the last cycle of
    // each dwell, which leaves the synchronizer time to settle after the
    // column changes; the same edge moves on to the next column.
    always_comb begin
        sample      = (div_q == DIV_LAST);
        eval_strobe = sample && (col_idx_q == 2'd3);
        div_d       = sample ? '0 : div_q + DIV_W'(1);
        col_idx_d   = sample ? col_idx_q + 2'd1 : col_idx_q;
        col_out     = ~(4'b0001 << col_idx_q);
    end

    // Frame accumulation. hits saturates at 2 (meaning "two or more"), and the
    // code is only meaningful while exactly one intersection has been seen.
    always_comb begin
        col_lows = ~sync2_q;
        col_hits = 3'd0;
        col_row  = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (col_lows[r]) begin
                col_hits = col_hits + 3'd1;
                col_row  = 2'(r);
            end
        end

        if (col_hits == 3'd0) begin
            frame_hits = hits_q;
            frame_code = acc_code_q;
        end else if (col_hits == 3'd1 && hits_q == 2'd0) begin
            frame_hits = 2'd1;
            frame_code = key_lookup(col_row, col_idx_q);
        end else begin
            frame_hits = 2'd2;
            frame_code = acc_code_q;
        end

        case (frame_hits)
            2'd0:    frame_result = FRAME_NONE;
            2'd1:    frame_result = FRAME_SINGLE;
            default: frame_result = FRAME_MULTI;
        endcase

        hits_d     = hits_q;
        acc_code_d = acc_code_q;
        if (sample) begin
            hits_d     = eval_strobe ? 2'd0 : frame_hits;
            acc_code_d = eval_strobe ? 4'd0 : frame_code;
        end
    end

    keypad_debounce_fsm #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk          (clk),
        .rst          (rst),
        .eval_strobe  (eval_strobe),
        .frame_result (frame_result),
        .frame_code   (frame_code),
        .accept       (accept),
        .accept_code  (accept_code)
    );

    // Entry register update. clear zeroes the base first so a coinciding
    // accept lands on an empty register.
    always_comb begin
        key_valid_d   = accept;
        key_code_d    = accept ? accept_code : key_code_q;
        value_base    = clear ? 32'h0 : value_q;
        value_d       = value_base;
        value_ready_d = 1'b0;
        if (accept) begin
`ifdef KEYPAD_CMD_KEYS_EN
            if (accept_code == KEY_BACKSPACE) begin
                value_d = {4'h0, value_base[31:4]};
            end else if (accept_code == KEY_ENTER) begin
                value_ready_d = 1'b1;
            end else begin
                value_d = {value_base[27:0], accept_code};
            end
`else
            value_d       = {value_base[27:0], accept_code};
            value_ready_d = 1'b1;
`endif
        end
    end

    // All state registers, reset together so a reset mid-scan or mid-debounce
    // leaves nothing behind.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q       <= 4'hF;
            sync2_q       <= 4'hF;
            div_q         <= '0;
            col_idx_q     <= 2'd0;
            hits_q        <= 2'd0;
            acc_code_q    <= 4'd0;
            key_valid_q   <= 1'b0;
            key_code_q    <= 4'd0;
            value_q       <= 32'h0;
            value_ready_q <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            div_q         <= div_d;
            col_idx_q     <= col_idx_d;
            hits_q        <= hits_d;
            acc_code_q    <= acc_code_d;
            key_valid_q   <= key_valid_d;
            key_code_q    <= key_code_d;
            value_q       <= value_d;
            value_ready_q <= value_ready_d;
        end
    end

    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign value       = value_q;
    assign value_ready = value_ready_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2
// (16-cycle frames). A behavioural keypad pulls rows low for pressed keys in
// the driven column. Expectations follow KEYPAD_CMD_KEYS_EN when defined.

module tb_keypad_scanner;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 2;
    localparam int FRAME          = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        clear;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [31:0] value;
    logic        value_ready;

    logic [15:0] keys;

    int checkCount  = 0;
    int errorCount  = 0;
    int validCount  = 0;
    int readyCount  = 0;
    int doublePulse = 0;
    logic prevValid = 1'b0;
    logic prevReady = 1'b0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .row_in      (row_in),
        .col_out     (col_out),
        .clear       (clear),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .value       (value),
        .value_ready (value_ready)
    );

    // Keypad model: key (r,c) shorts row r to column c.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (key_valid) validCount++;
        if (value_ready) readyCount++;
        if ((key_valid && prevValid) || (value_ready && prevReady)) doublePulse++;
        prevValid = key_valid;
        prevReady = value_ready;
    end

    function automatic logic [15:0] keyMask(input logic [3:0] code);
        case (code)
            4'h1: return 16'h0001;
            4'h2: return 16'h0002;
            4'h3: return 16'h0004;
            4'hA: return 16'h0008;
            4'h4: return 16'h0010;
            4'h5: return 16'h0020;
            4'h6: return 16'h0040;
            4'hB: return 16'h0080;
            4'h7: return 16'h0100;
            4'h8: return 16'h0200;
            4'h9: return 16'h0400;
            4'hC: return 16'h0800;
            4'hE: return 16'h1000;
            4'h0: return 16'h2000;
            4'hF: return 16'h4000;
            default: return 16'h8000;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] mask, input int cycles);
        keys = mask;
        waitCycles(cycles);
    endtask

    task automatic resetDut(input logic [15:0] held);
        keys  = held;
        clear = 1'b0;
        rst   = 1'b0;
        waitCycles(3);
        rst = 1'b1;
    endtask

    task automatic pressKey(input logic [3:0] code);
        applyStimulus(keyMask(code), 3 * FRAME);
        applyStimulus(16'h0, 3 * FRAME);
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        waitCycles(1);
        clear = 1'b0;
    endtask

    // Rising edges from now until key_valid is seen high, -1 on timeout.
    task automatic measureLatency(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            #1;
            if (key_valid) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        logic [3:0]  colSeq [4];
        logic [3:0]  digitSeq [12];
        logic [3:0]  cmdSeq [4];
        int          lat;
        int          baseValid;
        int          baseReady;
        logic        found;
        logic [3:0]  prevCol;

        colSeq   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        digitSeq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};
        cmdSeq   = '{4'h1, 4'h2, 4'hE, 4'hF};
        keys     = 16'h0;
        clear    = 1'b0;
        rst      = 1'b0;

        // Reset state and idle column rotation.
        resetDut(16'h0);
        checkOutput("rstColOut", 32'(col_out), 32'(4'b1110));
        checkOutput("rstKeyValid", 32'(key_valid), 32'h0);
        checkOutput("rstKeyCode", 32'(key_code), 32'h0);
        checkOutput("rstValue", value, 32'h0);
        checkOutput("rstValueReady", 32'(value_ready), 32'h0);
        for (int i = 1; i <= 18; i++) begin
            waitCycles(1);
            if (i % 4 == 2) checkOutput("colRotate", 32'(col_out), 32'(colSeq[(i / 4) % 4]));
        end
        waitCycles(3 * FRAME);
        checkOutput("idleNoEvent", 32'(validCount), 32'h0);
        checkOutput("idleValue", value, 32'h0);

        // '6' held from frame start: accept two frames after reset release.
        resetDut(keyMask(4'h6));
        measureLatency(lat);
        checkOutput("latency6", 32'(lat), 32'd32);
        checkOutput("code6", 32'(key_code), 32'h6);
        checkOutput("value6", value, 32'h6);
`ifdef KEYPAD_CMD_KEYS_EN
        checkOutput("ready6", 32'(value_ready), 32'h0);
`else
        checkOutput("ready6", 32'(value_ready), 32'h1);
`endif
        baseValid = validCount;
        waitCycles(2 * FRAME);
        applyStimulus(16'h0, 3 * FRAME);
        checkOutput("holdSingleEvent", 32'(validCount - baseValid), 32'h0);
        pressKey(4'h6);
        checkOutput("repressAfterRelease", 32'(validCount - baseValid), 32'h1);
        checkOutput("value66", value, 32'h66);
        pulseClear();
        checkOutput("clearValue", value, 32'h0);
        checkOutput("clearKeepsCode", 32'(key_code), 32'h6);

        // Digit entry and truncation.
        baseValid = validCount;
        for (int i = 0; i < 3; i++) pressKey(digitSeq[i]);
        checkOutput("value123", value, 32'h123);
        for (int i = 3; i < 12; i++) pressKey(digitSeq[i]);
        checkOutput("valueTrunc", value, 32'h56789ABC);
        checkOutput("digitEvents", 32'(validCount - baseValid), 32'd12);
        pulseClear();
        checkOutput("clearAfterDigits", value, 32'h0);
        checkOutput("codeC", 32'(key_code), 32'hC);

        // Multi-key frames and rollover while held.
        baseValid = validCount;
        applyStimulus(keyMask(4'h5) | keyMask(4'h8), 3 * FRAME);
        applyStimulus(16'h0, 3 * FRAME);
        checkOutput("multiNoEvent", 32'(validCount - baseValid), 32'h0);
        applyStimulus(keyMask(4'h5), 3 * FRAME);
        applyStimulus(keyMask(4'h5) | keyMask(4'h8), 3 * FRAME);
        applyStimulus(16'h0, 3 * FRAME);
        checkOutput("rolloverOneEvent", 32'(validCount - baseValid), 32'h1);
        checkOutput("rolloverCode", 32'(key_code), 32'h5);
        checkOutput("rolloverValue", value, 32'h5);

        // Bounce on '7' never reaches the debounce count.
        baseValid = validCount;
        applyStimulus(keyMask(4'h7), FRAME);
        applyStimulus(16'h0, FRAME);
        applyStimulus(keyMask(4'h7), FRAME);
        applyStimulus(16'h0, 3 * FRAME);
        checkOutput("bounceNoEvent", 32'(validCount - baseValid), 32'h0);
        checkOutput("bounceValue", value, 32'h5);

        // Reset while a candidate is pending, then keep holding the key.
        applyStimulus(keyMask(4'h7), FRAME + 4);
        resetDut(keyMask(4'h7));
        checkOutput("midResetValue", value, 32'h0);
        checkOutput("midResetNoEvent", 32'(validCount - baseValid), 32'h0);
        measureLatency(lat);
        checkOutput("latency7", 32'(lat), 32'd32);
        checkOutput("code7", 32'(key_code), 32'h7);
        checkOutput("value7", value, 32'h7);
        applyStimulus(16'h0, 3 * FRAME);

        // 1, 2, *, # with and without command keys.
        pulseClear();
        baseValid = validCount;
        baseReady = readyCount;
        for (int i = 0; i < 4; i++) pressKey(cmdSeq[i]);
        checkOutput("cmdEvents", 32'(validCount - baseValid), 32'd4);
        checkOutput("cmdCodeF", 32'(key_code), 32'hF);
`ifdef KEYPAD_CMD_KEYS_EN
        checkOutput("cmdValue", value, 32'h1);
        checkOutput("cmdReadyPulses", 32'(readyCount - baseReady), 32'd1);
`else
        checkOutput("cmdValue", value, 32'h12EF);
        checkOutput("cmdReadyPulses", 32'(readyCount - baseReady), 32'd4);
`endif

        // clear on the same edge as an accept: value holds only the new digit.
        found   = 1'b0;
        prevCol = col_out;
        for (int i = 0; i < 64 && !found; i++) begin
            prevCol = col_out;
            @(negedge clk);
            #1;
            if (prevCol == 4'b0111 && col_out == 4'b1110) found = 1'b1;
        end
        checkOutput("frameAlign", 32'(found), 32'h1);
        keys = keyMask(4'h9);
        waitCycles(2 * FRAME - 1);
        clear = 1'b1;
        waitCycles(1);
        clear = 1'b0;
        checkOutput("coinValid", 32'(key_valid), 32'h1);
        checkOutput("coinValue", value, 32'h9);
        checkOutput("coinCode", 32'(key_code), 32'h9);
        applyStimulus(16'h0, 3 * FRAME);

        checkOutput("noDoublePulse", 32'(doublePulse), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
